// File: rtl/pio_multi_channel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_multi_channel_pkg
//  Description : Register offsets and edge-type encodings shared by the
//                multi-channel PIO and its per-channel slice.
//  Revision    : 1.0  initial release
// ============================================================================
package pio_multi_channel_pkg;

    // Per-channel register offsets (address[2:0])
    localparam logic [2:0] REG_DATA      = 3'd0;
    localparam logic [2:0] REG_IN        = 3'd1;
    localparam logic [2:0] REG_IRQ_MASK  = 3'd2;
    localparam logic [2:0] REG_EDGE_CAP  = 3'd3;
    localparam logic [2:0] REG_OUTSET    = 3'd4;
    localparam logic [2:0] REG_OUTCLR    = 3'd5;
    localparam logic [2:0] REG_OUTTOGGLE = 3'd6;

    // EDGE_TYPE encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/pio_multi_channel_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pio_channel
//  Description : One PIO channel: output register with set/clear (and toggle
//                when PIO_TOGGLE_EN is defined), two-flop input synchroniser,
//                edge capture, interrupt mask and per-channel read mux.
//  Revision    : 1.0  initial release
// ============================================================================
module pio_channel
    import pio_multi_channel_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [2:0]       reg_sel,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] in_bits,
    output logic [WIDTH-1:0] out_bits,
    output logic [WIDTH-1:0] rd_val,
    output logic             irq_pend
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;

    // Edge detector selected at elaboration time
    if (EDGE_TYPE == EDGE_FALL) begin : g_edge_fall
        assign w_edge = ~r_s2 & r_prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
        assign w_edge = r_s2 ^ r_prev;
    end else begin : g_edge_rise
        assign w_edge = r_s2 & ~r_prev;
    end

    // Write-1-to-clear mask for the capture register
    assign w_clr = (wr_en && (reg_sel == REG_EDGE_CAP)) ? wd : '0;

    // Output register: plain write plus atomic set/clear/toggle strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= RESET_VALUE;
        end else if (wr_en) begin
            case (reg_sel)
                REG_DATA:      r_out <= wd;
                REG_OUTSET:    r_out <= r_out | wd;
                REG_OUTCLR:    r_out <= r_out & ~wd;
`ifdef PIO_TOGGLE_EN
                REG_OUTTOGGLE: r_out <= r_out ^ wd;
`endif
                default:       ;
            endcase
        end
    end

    // Input synchroniser and previous-sample flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= in_bits;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
        end else if (wr_en && (reg_sel == REG_IRQ_MASK)) begin
            r_mask <= wd;
        end
    end

    // Sticky capture; a new edge wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap <= '0;
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_edge;
        end
    end

    // Per-channel read mux; unreadable offsets return zero
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_DATA:     rd_val = r_out;
            REG_IN:       rd_val = r_s2;
            REG_IRQ_MASK: rd_val = r_mask;
            REG_EDGE_CAP: rd_val = r_cap;
            default:      rd_val = '0;
        endcase
    end

    assign out_bits = r_out;
    assign irq_pend = |(r_cap & r_mask);

endmodule
`default_nettype wire

// File: rtl/pio_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pio_multi_channel
//  Description : CHANNELS x WIDTH-bit GPIO block on an Avalon-MM slave with
//                zero-latency reads, edge capture and one level interrupt.
//                Optional macro PIO_TOGGLE_EN enables the OUTTOGGLE register.
//  Revision    : 1.0  initial release
// ============================================================================
module pio_multi_channel
    import pio_multi_channel_pkg::*;
#(
    parameter int          CHANNELS    = 2,
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          CH_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CH_BITS+2:0]        address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    input  logic [CHANNELS*WIDTH-1:0] in_port,
    output logic [CHANNELS*WIDTH-1:0] out_port,
    output logic                      irq
);

    logic [CH_BITS-1:0]  w_ch;
    logic [2:0]          w_reg;
    logic                w_wr;
    logic [CHANNELS-1:0] w_ch_wr;
    logic [CHANNELS-1:0] w_pend;
    logic [WIDTH-1:0]    w_rd [CHANNELS];
    logic [WIDTH-1:0]    w_rd_sel;
    logic                w_unused_wd;
    logic                r_irq;

    assign w_ch  = address[CH_BITS+2:3];
    assign w_reg = address[2:0];
    assign w_wr  = chipselect && !write_n;

    // Only the low WIDTH bits of writedata are meaningful
    assign w_unused_wd = ^writedata;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        // A channel index with no matching slice strobes nothing
        assign w_ch_wr[g] = w_wr && (w_ch == CH_BITS'(g));

        pio_channel #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE[WIDTH-1:0]),
            .EDGE_TYPE   (EDGE_TYPE)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (w_ch_wr[g]),
            .reg_sel  (w_reg),
            .wd       (writedata[WIDTH-1:0]),
            .in_bits  (in_port[g*WIDTH +: WIDTH]),
            .out_bits (out_port[g*WIDTH +: WIDTH]),
            .rd_val   (w_rd[g]),
            .irq_pend (w_pend[g])
        );
    end

    // Channel read select; nonexistent channels read as zero
    always_comb begin
        w_rd_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_ch == CH_BITS'(c)) begin
                w_rd_sel = w_rd[c];
            end
        end
    end

    // Zero-extend the selected channel value onto the 32-bit bus
    always_comb begin
        readdata             = '0;
        readdata[WIDTH-1:0]  = w_rd_sel;
    end

    // Registered level interrupt from any masked capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_pend;
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_pio_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pio_multi_channel
//  Description : Self-checking bench for pio_multi_channel (2 x 8 bits,
//                reset 0xA5, rising edge) plus a 3-channel instance for the
//                nonexistent-channel case. Honours PIO_TOGGLE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pio_multi_channel;

    localparam logic [31:0] RESET_VALUE = 32'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] in_port = '0;
    logic [15:0] out_port;
    logic        irq;

    logic [4:0]  address3 = '0;
    logic        chipselect3 = 1'b0;
    logic        write_n3 = 1'b1;
    logic [31:0] writedata3 = '0;
    logic [31:0] readdata3;
    logic [23:0] in_port3 = '0;
    logic [23:0] out_port3;
    logic        irq3;

    int checks = 0;
    int failures = 0;

    string       name_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    always #5 clk = ~clk;

    pio_multi_channel #(
        .CHANNELS(2), .WIDTH(8), .RESET_VALUE(RESET_VALUE), .EDGE_TYPE(0)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .irq(irq)
    );

    pio_multi_channel #(
        .CHANNELS(3), .WIDTH(8), .RESET_VALUE(RESET_VALUE), .EDGE_TYPE(0)
    ) dut3 (
        .clk(clk), .reset(reset), .address(address3), .chipselect(chipselect3),
        .write_n(write_n3), .writedata(writedata3), .readdata(readdata3),
        .in_port(in_port3), .out_port(out_port3), .irq(irq3)
    );

    // Scoreboard push of an expected value
    task automatic expect_val(input string n, input logic [31:0] v);
        name_q.push_back(n);
        exp_q.push_back(v);
    endtask

    // Single write cycle; called at a falling edge, returns at the next one
    task automatic bus_write(input int ch, input int r, input logic [31:0] d);
        address    = 4'((ch << 3) | r);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Combinational read sampled 1 ns after setting the address
    task automatic bus_read(input int ch, input int r, output logic [31:0] d);
        address    = 4'((ch << 3) | r);
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        expect_val("rst_out_port", 32'h0000_A5A5); obs_q.push_back({16'h0, out_port});
        expect_val("rst_irq", 32'h0);              obs_q.push_back({31'h0, irq});
        reset = 1'b0;
        @(negedge clk);
        expect_val("rst_ch0_data", 32'hA5); bus_read(0, 0, d); obs_q.push_back(d);
        expect_val("rst_ch1_mask", 32'h0);  bus_read(1, 2, d); obs_q.push_back(d);
        expect_val("rst_ch0_cap", 32'h0);   bus_read(0, 3, d); obs_q.push_back(d);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e; logic [31:0] o;
            n = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_data_set_clr();
        logic [31:0] d;
        bus_write(1, 0, 32'h3C);
        expect_val("data_out_port", 32'h3CA5); obs_q.push_back({16'h0, out_port});
        expect_val("data_rd_ch1", 32'h3C);     bus_read(1, 0, d); obs_q.push_back(d);
        bus_write(0, 4, 32'h0F);
        expect_val("outset", 32'hAF); obs_q.push_back({24'h0, out_port[7:0]});
        bus_write(0, 5, 32'h81);
        expect_val("outclr", 32'h2E); obs_q.push_back({24'h0, out_port[7:0]});
        bus_write(0, 1, 32'hFF);
        expect_val("in_reg_write_ignored", 32'h2E); obs_q.push_back({24'h0, out_port[7:0]});
        bus_write(0, 0, 32'hFFFF_FF00);
        expect_val("data_upper_ignored", 32'h00); obs_q.push_back({24'h0, out_port[7:0]});
        bus_write(0, 0, 32'hFFFF_FFFF);
        expect_val("rd_zero_ext", 32'h0000_00FF); bus_read(0, 0, d); obs_q.push_back(d);
        expect_val("ch1_untouched", 32'h3C); obs_q.push_back({24'h0, out_port[15:8]});
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e; logic [31:0] o;
            n = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        bus_write(1, 2, 32'h04);
        in_port[10] = 1'b1;                     // changes before edge k
        @(negedge clk);                         // after k
        @(negedge clk);                         // after k+1
        expect_val("in_sync", 32'h04);   bus_read(1, 1, d); obs_q.push_back(d);
        expect_val("cap_early", 32'h0);  bus_read(1, 3, d); obs_q.push_back(d);
        @(negedge clk);                         // after k+2
        expect_val("cap_set", 32'h04);   bus_read(1, 3, d); obs_q.push_back(d);
        expect_val("irq_early", 32'h0);  obs_q.push_back({31'h0, irq});
        @(negedge clk);                         // after k+3
        expect_val("irq_set", 32'h1);    obs_q.push_back({31'h0, irq});
        bus_write(1, 3, 32'h04);
        expect_val("cap_cleared", 32'h0); bus_read(1, 3, d); obs_q.push_back(d);
        expect_val("irq_hold", 32'h1);   obs_q.push_back({31'h0, irq});
        @(negedge clk);
        expect_val("irq_clear", 32'h0);  obs_q.push_back({31'h0, irq});
        in_port[10] = 1'b0;
        repeat (4) @(negedge clk);
        bus_write(1, 2, 32'h00);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e; logic [31:0] o;
            n = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        in_port[4] = 1'b1;
        repeat (3) @(negedge clk);
        expect_val("cap_bit4", 32'h10); bus_read(0, 3, d); obs_q.push_back(d);
        in_port[3] = 1'b1;                      // before edge k
        @(negedge clk);
        @(negedge clk);
        bus_write(0, 3, 32'h08);                // clear lands on edge k+2
        expect_val("set_wins", 32'h18); bus_read(0, 3, d); obs_q.push_back(d);
        bus_write(0, 3, 32'h08);
        expect_val("w1c_only_bit3", 32'h10); bus_read(0, 3, d); obs_q.push_back(d);
        bus_write(0, 3, 32'hFF);
        in_port[4:3] = 2'b00;
        repeat (4) @(negedge clk);
        expect_val("fall_no_cap", 32'h0); bus_read(0, 3, d); obs_q.push_back(d);
        expect_val("fall_no_irq", 32'h0); obs_q.push_back({31'h0, irq});
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e; logic [31:0] o;
            n = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_bad_channel();
        address3    = {2'd3, 3'd0};
        writedata3  = 32'h55;
        chipselect3 = 1'b1;
        write_n3    = 1'b0;
        @(negedge clk);
        chipselect3 = 1'b0;
        write_n3    = 1'b1;
        expect_val("badch_out_port", 32'h00A5_A5A5); obs_q.push_back({8'h0, out_port3});
        #1;
        expect_val("badch_rd_data", 32'h0); obs_q.push_back(readdata3);
        address3 = {2'd3, 3'd1}; #1;
        expect_val("badch_rd_in", 32'h0);   obs_q.push_back(readdata3);
        address3 = {2'd2, 3'd0}; #1;
        expect_val("ch2_rd_data", 32'hA5);  obs_q.push_back(readdata3);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e; logic [31:0] o;
            n = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(1, 2, 32'hFF);
        in_port[8] = 1'b1;
        repeat (4) @(negedge clk);
        expect_val("pre_rst_irq", 32'h1); obs_q.push_back({31'h0, irq});
        address    = {1'b0, 3'd0};
        writedata  = 32'h12;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #2 reset = 1'b1;                        // mid-write, away from the edge
        #1;
        expect_val("async_out_port", 32'hA5A5); obs_q.push_back({16'h0, out_port});
        expect_val("async_irq", 32'h0);         obs_q.push_back({31'h0, irq});
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        expect_val("post_rst_data", 32'hA5); bus_read(0, 0, d); obs_q.push_back(d);
        expect_val("post_rst_mask", 32'h0);  bus_read(1, 2, d); obs_q.push_back(d);
        expect_val("post_rst_cap", 32'h01);  bus_read(1, 3, d); obs_q.push_back(d);
        expect_val("post_rst_irq", 32'h0);   obs_q.push_back({31'h0, irq});
        in_port[8] = 1'b0;
        bus_write(1, 3, 32'hFF);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e; logic [31:0] o;
            n = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    task automatic test_toggle();
        logic [31:0] d;
        bus_write(0, 0, 32'hA5);
        bus_write(0, 6, 32'hFF);
`ifdef PIO_TOGGLE_EN
        expect_val("toggle_out", 32'h5A);
`else
        expect_val("toggle_out", 32'hA5);
`endif
        obs_q.push_back({24'h0, out_port[7:0]});
        expect_val("rd_reg6", 32'h0); bus_read(0, 6, d); obs_q.push_back(d);
        expect_val("rd_reg7", 32'h0); bus_read(0, 7, d); obs_q.push_back(d);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e; logic [31:0] o;
            n = name_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", n, o, e); end
        end
    endtask

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_data_set_clr();
        test_edge_irq();
        test_set_wins();
        test_bad_channel();
        test_reset_mid();
        test_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
